// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - tick prescaler, free-running tick count, CH countdown channels and irq arbiter
module timer_sched #(
    parameter int          CH          = 4,
    parameter logic [15:0] PRE_DEFAULT = 16'd50000,
    parameter int          IW          = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [3:0]    addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic          tick,
    output logic [15:0]   now,
    output logic          irq,
    output logic [IW-1:0] irq_id,
    input  logic          irq_ack
);
    localparam int CW = 2*CH+1;
    localparam logic [1:0] S_IDLE = 2'd0, S_ASSERT = 2'd1, S_GAP = 2'd2;

    logic [CW-1:0]  ctrl, ctrl_w, ctrl_nxt;
    logic [15:0]    prescale, pcnt;
    logic [15:0]    period [CH];
    logic [15:0]    cnt [CH];
    logic [CH-1:0]  pending, overrun;
    logic [CH-1:0]  ch_en, one_shot, expire, active, en_rise, wr_per;
    logic [CH-1:0]  clr_pend, clr_ovr, ack_mask, req;
    logic [1:0]     state;
    logic [IW-1:0]  sel;
    logic [15:0]    rd_val;
    logic           gen, wr_ctrl, wr_pre, wr_stat;

    assign gen      = ctrl[0];
    assign ch_en    = ctrl[CH:1];
    assign one_shot = ctrl[2*CH:CH+1];
    assign wr_ctrl  = wr && (addr == 4'd0);
    assign wr_pre   = wr && (addr == 4'd1);
    assign wr_stat  = wr && (addr == 4'd2);
    assign clr_pend = wr_stat ? wdata[CH-1:0] : '0;
    assign clr_ovr  = wr_stat ? wdata[2*CH-1:CH] : '0;
    assign ack_mask = (state == S_ASSERT && irq_ack) ? (CH'(1) << irq_id) : '0;
    assign tick     = gen && (pcnt == prescale);
    assign req      = pending & ~clr_pend;

    // CTRL can be wider than the data bus for large CH; unreachable bits write as 0
    always_comb begin
        ctrl_w = '0;
        for (int b = 0; b < CW && b < 16; b++) ctrl_w[b] = wdata[b];
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            wr_per[i]  = wr && (addr == 4'(4 + i));
            active[i]  = tick && ch_en[i] && (period[i] != 16'd0);
            expire[i]  = active[i] && (cnt[i] <= 16'd1);
            en_rise[i] = wr_ctrl && ctrl_w[i+1] && !ch_en[i];
        end
        ctrl_nxt = wr_ctrl ? ctrl_w : ctrl;
        for (int i = 0; i < CH; i++)
            if (expire[i] && one_shot[i]) ctrl_nxt[i+1] = 1'b0;
    end

    always_comb begin
        sel = '0;
        for (int i = CH-1; i >= 0; i--)
            if (req[i]) sel = IW'(i);
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            4'd0: for (int b = 0; b < CW && b < 16; b++) rd_val[b] = ctrl[b];
            4'd1: rd_val = prescale;
            4'd2: rd_val[2*CH-1:0] = {overrun, pending};
            4'd3: rd_val = now;
            default: begin
                for (int i = 0; i < CH; i++)
                    if (addr == 4'(4 + i)) rd_val = period[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl     <= '0;
            prescale <= PRE_DEFAULT;
            pcnt     <= '0;
            now      <= '0;
            rdata    <= '0;
            pending  <= '0;
            overrun  <= '0;
            for (int i = 0; i < CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            ctrl <= ctrl_nxt;
            if (wr_pre) prescale <= wdata;
            if (rd) rdata <= rd_val;
            if (!gen || wr_pre || tick) pcnt <= '0;
            else                        pcnt <= pcnt + 16'd1;
            if (tick) now <= now + 16'd1;
            // a fresh expiry beats an ack or W1C of the same bit and is not an overrun
            pending <= (pending & ~ack_mask & ~clr_pend) | expire;
            overrun <= (overrun & ~clr_ovr) | (expire & pending & ~ack_mask & ~clr_pend);
            for (int i = 0; i < CH; i++) begin
                if (wr_per[i]) begin
                    period[i] <= wdata;
                    cnt[i]    <= wdata;
                end else if (en_rise[i]) begin
                    cnt[i] <= period[i];
                end else if (expire[i]) begin
                    if (!one_shot[i]) cnt[i] <= period[i];
                end else if (active[i]) begin
                    cnt[i] <= cnt[i] - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            case (state)
                S_IDLE: if (|req) begin
                    irq    <= 1'b1;
                    irq_id <= sel;
                    state  <= S_ASSERT;
                end
                S_ASSERT: if (irq_ack) begin
                    irq   <= 1'b0;
                    state <= S_GAP;
                end else if (clr_pend[irq_id]) begin
                    irq   <= 1'b0;
                    state <= S_IDLE;
                end
                S_GAP: state <= S_IDLE;
                default: begin
                    irq   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
